// File: rtl/echo_encoder_display.sv
// echo_encoder_display: registered nibble capture, 5-bit display code and seven-segment decode.
// Define ECHO_BCD_CHECK_EN to show a dash for captured values 10..15 instead of hex A..F.
module echo_encoder_display (
    input  logic CLK,
    input  logic RST,
    input  logic RE,
    input  logic RS,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic S4,
    output logic S5,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g
);
    localparam logic [4:0] BLANK = 5'b10000;
    localparam logic [4:0] DASH  = 5'b10001;
    logic [3:0] nib;
    logic [4:0] enc;
    logic [4:0] code;
    logic [6:0] seg;
    assign nib = {A, B, C, D};
`ifdef ECHO_BCD_CHECK_EN
    assign enc = (nib > 4'd9) ? DASH : {1'b0, nib};
`else
    assign enc = {1'b0, nib};
`endif
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            code <= BLANK;
        else if (RS)
            code <= BLANK;
        else if (RE)
            code <= enc;
    end
    // Reserved special codes fall through to the blank default.
    always_comb begin
        seg = 7'b0000000;
        case (code)
            5'h00: seg = 7'b1111110;
            5'h01: seg = 7'b0110000;
            5'h02: seg = 7'b1101101;
            5'h03: seg = 7'b1111001;
            5'h04: seg = 7'b0110011;
            5'h05: seg = 7'b1011011;
            5'h06: seg = 7'b1011111;
            5'h07: seg = 7'b1110000;
            5'h08: seg = 7'b1111111;
            5'h09: seg = 7'b1111011;
            5'h0a: seg = 7'b1110111;
            5'h0b: seg = 7'b0011111;
            5'h0c: seg = 7'b1001110;
            5'h0d: seg = 7'b0111101;
            5'h0e: seg = 7'b1001111;
            5'h0f: seg = 7'b1000111;
            DASH:  seg = 7'b0000001;
            default: seg = 7'b0000000;
        endcase
    end
    assign {S1, S2, S3, S4, S5} = code;
    assign {a, b, c, d, e, f, g} = seg;
endmodule

// File: tb/tb_echo_encoder_display.sv
// tb_echo_encoder_display: vector table, hand sequences and randomized run against a reference model.
module tb_echo_encoder_display;
    logic CLK, RST, RE, RS, A, B, C, D;
    logic S1, S2, S3, S4, S5, a, b, c, d, e, f, g;
    int total = 0;
    int passed = 0;

    typedef struct {
        logic       re;
        logic       rs;
        logic [3:0] n;
        logic [4:0] code;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    echo_encoder_display dut (
        .CLK(CLK), .RST(RST), .RE(RE), .RS(RS),
        .A(A), .B(B), .C(C), .D(D),
        .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [4:0] enc_of(input logic [3:0] n);
`ifdef ECHO_BCD_CHECK_EN
        return (int'(n) >= 10) ? 5'b10001 : {1'b0, n};
`else
        return {1'b0, n};
`endif
    endfunction

    function automatic logic [6:0] seg_of(input logic [4:0] cd);
        if (!cd[4])
            return HEX[cd[3:0]];
        return (cd == 5'b10001) ? 7'b0000001 : 7'b0000000;
    endfunction

    task automatic drive(input logic re, input logic rs, input logic [3:0] n);
        RE = re;
        RS = rs;
        {A, B, C, D} = n;
    endtask

    task automatic check(input string name, input logic [4:0] ecode, input logic [6:0] eseg);
        logic [4:0] acode;
        logic [6:0] aseg;
        acode = {S1, S2, S3, S4, S5};
        aseg = {a, b, c, d, e, f, g};
        total++;
        if (acode === ecode && aseg === eseg)
            passed++;
        else
            $display("FAIL %s: got code %b seg %b, expected code %b seg %b", name, acode, aseg, ecode, eseg);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    logic [4:0] model;

    initial begin
        for (int i = 0; i < 16; i++)
            vecs.push_back('{1'b1, 1'b0, 4'(i), enc_of(4'(i)), seg_of(enc_of(4'(i)))});
        vecs.push_back('{1'b1, 1'b0, 4'b0111, 5'b00111, 7'b1110000});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 1'b0, 4'b0001, 5'b00111, 7'b1110000});
        vecs.push_back('{1'b1, 1'b0, 4'b1000, 5'b01000, 7'b1111111});
        vecs.push_back('{1'b1, 1'b1, 4'b0010, 5'b10000, 7'b0000000});
        vecs.push_back('{1'b0, 1'b0, 4'b0011, 5'b10000, 7'b0000000});

        RST = 1'b1;
        drive(1'b1, 1'b0, 4'b0101);
        #2;
        check("reset_async", 5'b10000, 7'b0000000);
        #5;
        RST = 1'b0;
        check("reset_hold", 5'b10000, 7'b0000000);

        foreach (vecs[i]) begin
            drive(vecs[i].re, vecs[i].rs, vecs[i].n);
            tick();
            check($sformatf("vec%0d", i), vecs[i].code, vecs[i].seg);
        end

        drive(1'b1, 1'b0, 4'b0100);
        tick();
        check("lat_cap", 5'b00100, 7'b0110011);
        #3;
        drive(1'b1, 1'b0, 4'b1001);
        #1;
        check("lat_mid", 5'b00100, 7'b0110011);
        tick();
        check("lat_edge", 5'b01001, 7'b1111011);

        drive(1'b0, 1'b0, 4'b0110);
        #2;
        RST = 1'b1;
        #1;
        check("mid_reset", 5'b10000, 7'b0000000);
        #2;
        RST = 1'b0;
        tick();
        check("post_reset_hold", 5'b10000, 7'b0000000);

        model = 5'b10000;
        for (int i = 0; i < 300; i++) begin
            logic re, rs;
            logic [3:0] n;
            re = 1'($urandom % 2);
            rs = ($urandom % 8) == 0;
            n = 4'($urandom % 16);
            drive(re, rs, n);
            if (rs)
                model = 5'b10000;
            else if (re)
                model = enc_of(n);
            tick();
            check($sformatf("rand%0d", i), model, seg_of(model));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
